// File: rtl/dvs_event_queue_sched_if.sv
// ----------------------------------------------------------------------------
// dvs_event_queue_sched_if
//
// Bundles the scheduler's handshake and bus signals:
//   - producer side : src_valid, src_event (producer i at [i*EVENT_BITS +: EVENT_BITS]),
//                     src_ready (one-hot grant)
//   - queue side    : q_event_in, q_wr_en, q_rd_en, q_event_out, q_empty, q_full
//   - output side   : out_valid, out_event, out_ready
//
// Modports:
//   master : the scheduler (drives grants, queue strobes and the output register)
//   slave  : the environment (producers, queue and downstream consumer)
// ----------------------------------------------------------------------------
interface dvs_event_queue_sched_if #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned EVENT_BITS = 12
);
    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC*EVENT_BITS-1:0] src_event;
    logic [NUM_SRC-1:0]            src_ready;

    logic [EVENT_BITS-1:0]         q_event_in;
    logic                          q_wr_en;
    logic                          q_rd_en;
    logic [EVENT_BITS-1:0]         q_event_out;
    logic                          q_empty;
    logic                          q_full;

    logic                          out_valid;
    logic [EVENT_BITS-1:0]         out_event;
    logic                          out_ready;

    modport master (
        input  src_valid, src_event, q_event_out, q_empty, q_full, out_ready,
        output src_ready, q_event_in, q_wr_en, q_rd_en, out_valid, out_event
    );

    modport slave (
        output src_valid, src_event, q_event_out, q_empty, q_full, out_ready,
        input  src_ready, q_event_in, q_wr_en, q_rd_en, out_valid, out_event
    );
endinterface

// File: rtl/dvs_event_queue_sched.sv
// ----------------------------------------------------------------------------
// dvs_event_queue_sched
//
// Scheduler in front of a single-port DVS event FIFO. Each cycle it performs at
// most one queue operation: a round-robin arbitrated write from one of NUM_SRC
// producers, or a read whose data is captured into a valid/ready output register.
// Writes may starve reads for at most STARVE_LIMIT consecutive cycles.
//
// Ports:
//   clk        : system clock
//   rst        : asynchronous, active-high reset
//   bus        : dvs_event_queue_sched_if.master (producer, queue and output signals)
//   drop_count : 16-bit saturating count of discarded events
//                (present only when DVS_QUEUE_DROP_CNT_EN is defined)
//
// Build option:
//   DVS_QUEUE_DROP_CNT_EN : when the queue is full, the round-robin winner is still
//                           granted and its event discarded and counted, instead of
//                           backpressuring the producers.
// ----------------------------------------------------------------------------
module dvs_event_queue_sched #(
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned EVENT_BITS   = 12,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    dvs_event_queue_sched_if.master bus
`ifdef DVS_QUEUE_DROP_CNT_EN
    ,
    output logic [15:0]            drop_count
`endif
);
    localparam int unsigned PtrW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  out_valid_q, out_valid_d;
    logic [EVENT_BITS-1:0] out_event_q, out_event_d;

    logic                  any_valid;
    logic                  read_elig;
    logic                  wr_req;
    logic                  do_read;
    logic                  do_write;
    logic                  do_drop;
    logic                  do_grant;

    logic [PtrW-1:0]       win_idx;
    logic [NUM_SRC-1:0]    win_oh;
    logic [EVENT_BITS-1:0] win_event;
    logic                  win_found;
    logic [PtrW-1:0]       next_ptr;

    // Round-robin search: first pass covers rr_ptr..NUM_SRC-1, second pass wraps
    // around to 0..rr_ptr-1.
    always_comb begin
        win_idx   = '0;
        win_oh    = '0;
        win_event = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!win_found && (i >= 32'(rr_ptr_q)) && bus.src_valid[i]) begin
                win_found = 1'b1;
                win_idx   = PtrW'(i);
                win_oh[i] = 1'b1;
                win_event = bus.src_event[i*EVENT_BITS +: EVENT_BITS];
            end
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!win_found && (i < 32'(rr_ptr_q)) && bus.src_valid[i]) begin
                win_found = 1'b1;
                win_idx   = PtrW'(i);
                win_oh[i] = 1'b1;
                win_event = bus.src_event[i*EVENT_BITS +: EVENT_BITS];
            end
        end
    end

    assign next_ptr = (32'(win_idx) == NUM_SRC - 1) ? '0 : win_idx + 1'b1;

    assign any_valid = |bus.src_valid;
    // Only read into a free output slot: no read in flight and nothing held.
    assign read_elig = !bus.q_empty && !rd_inflight_q && !out_valid_q;
    assign wr_req    = any_valid && !bus.q_full;
    assign do_read   = read_elig && (!wr_req || (starve_cnt_q == 4'(STARVE_LIMIT)));
    assign do_write  = !do_read && wr_req;

`ifdef DVS_QUEUE_DROP_CNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    assign do_drop = !do_read && bus.q_full && any_valid;

    always_comb begin
        drop_count_d = drop_count_q;
        if (do_drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign do_drop = 1'b0;
`endif

    assign do_grant = do_write || do_drop;

    // Strobes are forced low while reset is held.
    always_comb begin
        bus.src_ready  = (do_grant && !rst) ? win_oh : '0;
        bus.q_wr_en    = do_write && !rst;
        bus.q_rd_en    = do_read && !rst;
        bus.q_event_in = win_event;
        bus.out_valid  = out_valid_q;
        bus.out_event  = out_event_q;
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        rd_inflight_d = do_read;
        out_valid_d   = out_valid_q;
        out_event_d   = out_event_q;
        starve_cnt_d  = starve_cnt_q;

        if (do_grant) begin
            rr_ptr_d = next_ptr;
        end

        // Queue data is valid the cycle after the read strobe.
        if (rd_inflight_q) begin
            out_valid_d = 1'b1;
            out_event_d = bus.q_event_out;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (do_read || !read_elig) begin
            starve_cnt_d = '0;
        end else if (do_write && (starve_cnt_q < 4'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            starve_cnt_q  <= '0;
            rd_inflight_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_event_q   <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            starve_cnt_q  <= starve_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            out_valid_q   <= out_valid_d;
            out_event_q   <= out_event_d;
        end
    end
endmodule

// File: tb/tb_dvs_event_queue_sched.sv
// ----------------------------------------------------------------------------
// tb_dvs_event_queue_sched
//
// Drives the scheduler with directed and random producer/consumer traffic. A FIFO
// queue model stands in for the event queue; a behavioural model of the scheduling
// rules predicts grants, strobes and the output register each cycle, and an
// end-to-end scoreboard checks every accepted event leaves once and in order.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_dvs_event_queue_sched;
    localparam int unsigned NUM_SRC      = 2;
    localparam int unsigned EVENT_BITS   = 12;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned QDEPTH       = 8;
    localparam int unsigned EvW          = NUM_SRC * EVENT_BITS;

    logic clk;
    logic rst;

    dvs_event_queue_sched_if #(.NUM_SRC(NUM_SRC), .EVENT_BITS(EVENT_BITS)) bus ();

`ifdef DVS_QUEUE_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    dvs_event_queue_sched #(
        .NUM_SRC     (NUM_SRC),
        .EVENT_BITS  (EVENT_BITS),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DVS_QUEUE_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Queue and scheduling model state.
    int unsigned fq[$];
    int unsigned sb[$];
    int unsigned m_rr;
    int unsigned m_starve;
    bit          m_inflight;
    bit          m_ov;
    int unsigned m_oe;
    int unsigned m_rd_data;
    int unsigned m_drop;

    // Per-cycle predictions.
    bit e_elig, e_rd, e_wr, e_drop;
    int e_win;

    // DUT observations from the last sampled cycle.
    logic [NUM_SRC-1:0]    obs_ready;
    logic                  obs_rd, obs_wr, obs_ov;
    logic [EVENT_BITS-1:0] obs_oe, obs_ev_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned slice_ev(input int unsigned i);
        logic [EvW-1:0] v;
        v = bus.src_event;
        return 32'(v[i*EVENT_BITS +: EVENT_BITS]);
    endfunction

    task automatic drive_queue_outputs();
        bus.q_empty     = (fq.size() == 0);
        bus.q_full      = (fq.size() >= QDEPTH);
        bus.q_event_out = EVENT_BITS'(m_rd_data);
    endtask

    task automatic model_reset();
        fq.delete();
        sb.delete();
        m_rr       = 0;
        m_starve   = 0;
        m_inflight = 0;
        m_ov       = 0;
        m_oe       = 0;
        m_rd_data  = 0;
        m_drop     = 0;
    endtask

    // Falling-edge comparison of the DUT against the model's predictions.
    task automatic model_check();
        bit [NUM_SRC-1:0] sv;
        bit               any, full, wreq;
        int unsigned      exp_ready;

        obs_ready = bus.src_ready;
        obs_rd    = bus.q_rd_en;
        obs_wr    = bus.q_wr_en;
        obs_ov    = bus.out_valid;
        obs_oe    = bus.out_event;
        obs_ev_in = bus.q_event_in;

        if (rst) begin
            chk("rst_src_ready", 32'(bus.src_ready), 0);
            chk("rst_wr_en", 32'(bus.q_wr_en), 0);
            chk("rst_rd_en", 32'(bus.q_rd_en), 0);
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_out_event", 32'(bus.out_event), 0);
            return;
        end

        sv     = bus.src_valid;
        any    = (sv != 0);
        full   = (fq.size() >= QDEPTH);
        wreq   = any && !full;
        e_elig = (fq.size() > 0) && !m_inflight && !m_ov;
        e_rd   = e_elig && (!wreq || (m_starve == STARVE_LIMIT));
        e_wr   = !e_rd && wreq;
        e_drop = 0;
`ifdef DVS_QUEUE_DROP_CNT_EN
        e_drop = !e_rd && full && any;
`endif
        e_win = -1;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            int unsigned c;
            c = (m_rr + k) % NUM_SRC;
            if (e_win < 0 && sv[c]) e_win = int'(c);
        end
        exp_ready = (e_wr || e_drop) ? (32'd1 << e_win) : 0;

        chk("src_ready", 32'(bus.src_ready), exp_ready);
        chk("q_wr_en", 32'(bus.q_wr_en), 32'(e_wr));
        chk("q_rd_en", 32'(bus.q_rd_en), 32'(e_rd));
        chk("wr_rd_exclusive", 32'(bus.q_wr_en & bus.q_rd_en), 0);
        if (e_wr) chk("q_event_in", 32'(bus.q_event_in), slice_ev(e_win));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (m_ov) chk("out_event", 32'(bus.out_event), m_oe);
`ifdef DVS_QUEUE_DROP_CNT_EN
        chk("drop_count", 32'(drop_count), m_drop);
`endif
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else chk("sb_order", 32'(bus.out_event), sb.pop_front());
        end
    endtask

    // Advances the model by one clock using the inputs that were held over the edge.
    task automatic model_update();
        if (rst) begin
            model_reset();
        end else begin
            if (m_inflight) begin
                m_ov = 1;
                m_oe = m_rd_data;
            end else if (m_ov && bus.out_ready) begin
                m_ov = 0;
            end
            m_inflight = e_rd;
            if (e_rd) m_rd_data = fq.pop_front();
            if (e_rd || !e_elig) m_starve = 0;
            else if (e_wr) m_starve++;
            if (e_wr) begin
                fq.push_back(slice_ev(e_win));
                sb.push_back(slice_ev(e_win));
            end
            if (e_wr || e_drop) m_rr = (e_win + 1) % NUM_SRC;
            if (e_drop && m_drop < 65535) m_drop++;
        end
        drive_queue_outputs();
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [NUM_SRC-1:0] t2_ready[6];
    logic               t2_rd[6];
    int unsigned        t2_first;
    bit                 seen;
    int unsigned        ready_pct;

    initial begin
        rst           = 1'b1;
        bus.src_valid = '0;
        bus.src_event = '0;
        bus.out_ready = 1'b0;
        model_reset();
        drive_queue_outputs();
        e_elig = 0; e_rd = 0; e_wr = 0; e_drop = 0; e_win = -1;

        // Reset, then a single event from src0 flows through to the output.
        apply_reset();
        bus.out_ready = 1'b1;
        bus.src_valid = 2'b01;
        bus.src_event = {12'h000, 12'h0A1};
        tick();
        chk("t1_wr_en", 32'(obs_wr), 1);
        chk("t1_event_in", 32'(obs_ev_in), 32'h0A1);
        bus.src_valid = '0;
        tick();
        chk("t1_rd_en", 32'(obs_rd), 1);
        tick();
        chk("t1_inflight_no_valid", 32'(obs_ov), 0);
        tick();
        chk("t1_out_valid", 32'(obs_ov), 1);
        chk("t1_out_event", 32'(obs_oe), 32'h0A1);
        tick();

        // Both producers valid: alternating grants, one read after STARVE_LIMIT writes.
        apply_reset();
        bus.out_ready = 1'b1;
        bus.src_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            bus.src_event = EvW'($urandom);
            if (i == 0) t2_first = slice_ev(0);
            tick();
            t2_ready[i] = obs_ready;
            t2_rd[i]    = obs_rd;
        end
        chk("t2_grant0", 32'(t2_ready[0]), 1);
        chk("t2_grant1", 32'(t2_ready[1]), 2);
        chk("t2_grant2", 32'(t2_ready[2]), 1);
        chk("t2_grant3", 32'(t2_ready[3]), 2);
        chk("t2_grant4", 32'(t2_ready[4]), 1);
        chk("t2_read_slot_ready", 32'(t2_ready[5]), 0);
        for (int i = 0; i < 5; i++) chk("t2_no_read", 32'(t2_rd[i]), 0);
        chk("t2_read_inserted", 32'(t2_rd[5]), 1);

        // Output held for 10 cycles: event stable, no reads, queue fills up.
        bus.out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            bus.src_event = EvW'($urandom);
            tick();
            seen = obs_ov;
        end
        chk("t3_out_valid_seen", 32'(seen), 1);
        for (int i = 0; i < 10; i++) begin
            bus.src_event = EvW'($urandom);
            tick();
            chk("t3_hold_valid", 32'(obs_ov), 1);
            chk("t3_hold_event", 32'(obs_oe), t2_first);
            chk("t3_hold_no_read", 32'(obs_rd), 0);
        end
        chk("t3_full_no_write", 32'(obs_wr), 0);
`ifdef DVS_QUEUE_DROP_CNT_EN
        chk("t3_full_drop_grant", 32'(obs_ready != 0), 1);
`else
        chk("t3_full_backpressure", 32'(obs_ready), 0);
`endif
        bus.out_ready = 1'b1;
        bus.src_valid = '0;
        tick();
        chk("t3_accept_valid", 32'(obs_ov), 1);
        tick();
        chk("t3_after_accept_valid", 32'(obs_ov), 0);
        chk("t3_after_accept_read", 32'(obs_rd), 1);

        // Reset lands one cycle after the read strobe: the read is discarded.
        apply_reset();
        bus.src_valid = 2'b11;
        bus.src_event = EvW'($urandom);
        tick();
        chk("t5_first_grant_src0", 32'(obs_ready), 1);
        chk("t5_out_valid_low", 32'(obs_ov), 0);
        bus.src_event = EvW'($urandom);
        tick();
        chk("t5_out_valid_still_low", 32'(obs_ov), 0);

        // Random traffic with varying downstream pressure and rare resets.
        ready_pct = 75;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 500 == 0) ready_pct = $urandom_range(10, 100);
            bus.src_valid = NUM_SRC'($urandom);
            bus.src_event = EvW'($urandom);
            bus.out_ready = ($urandom_range(1, 100) <= ready_pct);
            if ($urandom_range(0, 2999) == 0) apply_reset();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
